// File: rtl/clock_pkg.sv
// Shared definitions for the alarm/clock slice.
// Packed live/alarm time layout (BCD, 20 bits):
//   {h10[19:18], h1[17:14], m10[13:11], m1[10:7], s10[6:4], s1[3:0]}
// Provides field offsets, the 24h slot type, the alarm FSM state enum
// and a BCD digit validity check.
package clock_pkg;

  localparam int unsigned TIME_W  = 20;
  localparam int unsigned S1_LSB  = 0;
  localparam int unsigned S10_LSB = 4;
  localparam int unsigned M1_LSB  = 7;
  localparam int unsigned M10_LSB = 11;
  localparam int unsigned H1_LSB  = 14;
  localparam int unsigned H10_LSB = 18;
  localparam int unsigned HH_W    = 6;
  localparam int unsigned MM_W    = 7;
  localparam int unsigned SS_W    = 7;

  typedef struct packed {
    logic [HH_W-1:0] hh;
    logic [MM_W-1:0] mm;
  } time24_t;

  typedef enum logic [1:0] {
    IDLE,
    RINGING,
    SNOOZE
  } alarm_state_e;

  function automatic logic bcd_ok(input logic [3:0] d);
    return d <= 4'd9;
  endfunction

endpackage

// File: rtl/alarm_bank_if.sv
// Alarm store write/clear bus.
//   set_alarm   : write-slot strobe (rising edge acts)
//   clr_alarm   : disable-slot strobe (rising edge acts)
//   alarm_id    : target slot
//   stime_alarm : alarm time, packed BCD (seconds ignored)
//   sam_pm      : PM flag of stime_alarm in 12h mode
//   alarm_en    : per-slot enable (from the store)
//   wr_err      : one-cycle pulse on a rejected write (from the store)
interface alarm_bank_if;
  logic        set_alarm;
  logic        clr_alarm;
  logic [1:0]  alarm_id;
  logic [19:0] stime_alarm;
  logic        sam_pm;
  logic [3:0]  alarm_en;
  logic        wr_err;

  modport master (
    output set_alarm, clr_alarm, alarm_id, stime_alarm, sam_pm,
    input  alarm_en, wr_err
  );

  modport slave (
    input  set_alarm, clr_alarm, alarm_id, stime_alarm, sam_pm,
    output alarm_en, wr_err
  );
endinterface

// File: rtl/to_24h.sv
// Combinational BCD hour converter to 24h format.
//   hour    : BCD hour {h10[5:4], h1[3:0]}
//   pm      : PM flag (used only when mode12h=1)
//   mode12h : 1 = hour is 01-12 with pm, 0 = hour is already 00-23
//   hour24  : BCD hour 00-23
//   valid   : hour is legal for the selected mode
module to_24h
  import clock_pkg::*;
(
  input  logic [5:0] hour,
  input  logic       pm,
  input  logic       mode12h,
  output logic [5:0] hour24,
  output logic       valid
);
  logic [1:0] w_h10;
  logic [3:0] w_h1;
  logic       w_digits_ok;
  logic [4:0] w_bin;
  logic [4:0] w_bin24;

  // Work in binary, then split back into BCD digits.
  always_comb begin
    w_h10       = hour[5:4];
    w_h1        = hour[3:0];
    w_digits_ok = bcd_ok(w_h1) && (w_h10 <= 2'd2);
    w_bin       = ({3'b000, w_h10} * 5'd10) + {1'b0, w_h1};
    valid       = 1'b0;
    w_bin24     = w_bin;
    if (mode12h) begin
      valid = w_digits_ok && (w_bin >= 5'd1) && (w_bin <= 5'd12);
      if (w_bin == 5'd12) w_bin24 = pm ? 5'd12 : 5'd0;
      else if (pm)        w_bin24 = w_bin + 5'd12;
    end else begin
      valid = w_digits_ok && (w_bin <= 5'd23);
    end
    if (w_bin24 >= 5'd20)      hour24 = {2'd2, 4'(w_bin24 - 5'd20)};
    else if (w_bin24 >= 5'd10) hour24 = {2'd1, 4'(w_bin24 - 5'd10)};
    else                       hour24 = {2'd0, w_bin24[3:0]};
  end
endmodule

// File: rtl/alarm_bank.sv
// Four-slot alarm store with match detection and ring/snooze/stop FSM.
//   clk, rst    : clock, asynchronous active-low reset
//   hh_mm_ss    : live time, packed BCD; am_pm : live PM flag (12h mode)
//   mode12h     : 12h format for live and alarm times
//   bus         : alarm write/clear bus (slave side)
//   snooze_btn  : snooze level; stop_btn : stop level (rising edges act)
//   ring        : ring request; ring_id : active slot
//   snoozing    : high while snoozing; missed : sticky dropped-match flag
module alarm_bank
  import clock_pkg::*;
#(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [19:0]   hh_mm_ss,
  input  logic          am_pm,
  input  logic          mode12h,
  alarm_bank_if.slave   bus,
  input  logic          snooze_btn,
  input  logic          stop_btn,
  output logic          ring,
  output logic [1:0]    ring_id,
  output logic          snoozing,
  output logic          missed
);
  localparam int unsigned CNT_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned SW      = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;

  alarm_state_e   r_state;
  time24_t        r_slot [4];
  logic [3:0]     r_alarm_en;
  logic           r_wr_err, r_ring, r_snoozing, r_missed;
  logic [1:0]     r_ring_id;
  logic [CW-1:0]  r_ring_cnt, r_wait_cnt;
  logic [SW-1:0]  r_snz_cnt;
  logic [3:0]     r_in_s, r_in_h;   // {stop, snooze, clr, set}
  logic [3:0]     r_s1;

  logic [3:0] w_rise;
  logic       w_set, w_clr, w_snooze, w_stop;
  logic [5:0] w_wr_hour24, w_live_hour24;
  logic       w_wr_hok, w_live_hok, w_wr_ok;
  logic       w_tick, w_sec00;
  time24_t    w_live;
  logic [3:0] w_match;
  logic       w_multi;
  logic [1:0] w_first;
  logic       w_unused_secs;

  assign w_rise   = r_in_s & ~r_in_h;
  assign w_set    = w_rise[0];
  assign w_clr    = w_rise[1];
  assign w_snooze = w_rise[2];
  assign w_stop   = w_rise[3];

  to_24h u_wr_conv (
    .hour(bus.stime_alarm[19:14]), .pm(bus.sam_pm), .mode12h(mode12h),
    .hour24(w_wr_hour24), .valid(w_wr_hok)
  );

  to_24h u_live_conv (
    .hour(hh_mm_ss[19:14]), .pm(am_pm), .mode12h(mode12h),
    .hour24(w_live_hour24), .valid(w_live_hok)
  );

  assign w_wr_ok       = w_wr_hok && bcd_ok(bus.stime_alarm[10:7]) && (bus.stime_alarm[13:11] <= 3'd5);
  assign w_unused_secs = ^bus.stime_alarm[6:0];
  assign w_live        = '{hh: w_live_hour24, mm: hh_mm_ss[13:7]};
  assign w_sec00       = (hh_mm_ss[6:0] == 7'd0);
  assign w_tick        = (hh_mm_ss[3:0] != r_s1);

  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      w_match[i] = w_tick && w_sec00 && w_live_hok && r_alarm_en[i] && (r_slot[i] == w_live);
    end
    if (w_match[0])      w_first = 2'd0;
    else if (w_match[1]) w_first = 2'd1;
    else if (w_match[2]) w_first = 2'd2;
    else                 w_first = 2'd3;
    // More than one bit set: clearing the lowest set bit leaves something.
    w_multi = ((w_match & (w_match - 4'd1)) != 4'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      for (int unsigned i = 0; i < 4; i++) r_slot[i] <= '0;
      r_alarm_en <= '0;
      r_wr_err   <= 1'b0;
      r_ring     <= 1'b0;
      r_snoozing <= 1'b0;
      r_missed   <= 1'b0;
      r_ring_id  <= '0;
      r_ring_cnt <= '0;
      r_wait_cnt <= '0;
      r_snz_cnt  <= '0;
      r_in_s     <= '0;
      r_in_h     <= '0;
      r_s1       <= '0;
    end else begin
      r_in_s   <= {stop_btn, snooze_btn, bus.clr_alarm, bus.set_alarm};
      r_in_h   <= r_in_s;
      r_s1     <= hh_mm_ss[3:0];
      r_wr_err <= 1'b0;

      // Writing the active slot only updates the stored time.
      if (w_set) begin
        if (w_wr_ok) begin
          r_slot[bus.alarm_id]     <= '{hh: w_wr_hour24, mm: bus.stime_alarm[13:7]};
          r_alarm_en[bus.alarm_id] <= 1'b1;
        end else begin
          r_wr_err <= 1'b1;
        end
      end
      if (w_clr) r_alarm_en[bus.alarm_id] <= 1'b0;

      if (w_stop)                                        r_missed <= 1'b0;
      else if (w_multi || (r_state != IDLE && |w_match)) r_missed <= 1'b1;

      case (r_state)
        IDLE: begin
          if (|w_match) begin
            r_state    <= RINGING;
            r_ring     <= 1'b1;
            r_ring_id  <= w_first;
            r_ring_cnt <= CW'(RING_SECS);
            r_snz_cnt  <= '0;
          end
        end
        RINGING, SNOOZE: begin
          if (w_clr && (bus.alarm_id == r_ring_id)) begin
            r_state    <= IDLE;
            r_ring     <= 1'b0;
            r_snoozing <= 1'b0;
            r_snz_cnt  <= '0;
          end else if (w_stop) begin
            r_state    <= IDLE;
            r_ring     <= 1'b0;
            r_snoozing <= 1'b0;
          end else if (r_state == RINGING && w_snooze) begin
            if (r_snz_cnt < SW'(MAX_SNOOZE)) begin
              r_state    <= SNOOZE;
              r_ring     <= 1'b0;
              r_snoozing <= 1'b1;
              r_wait_cnt <= CW'(SNOOZE_SECS);
              r_snz_cnt  <= r_snz_cnt + 1'b1;
            end else begin
              r_state    <= IDLE;
              r_ring     <= 1'b0;
              r_snoozing <= 1'b0;
            end
          end else if (w_tick) begin
            if (r_state == RINGING) begin
              r_ring_cnt <= r_ring_cnt - 1'b1;
              if (r_ring_cnt == CW'(1)) begin
                r_state <= IDLE;
                r_ring  <= 1'b0;
              end
            end else begin
              r_wait_cnt <= r_wait_cnt - 1'b1;
              if (r_wait_cnt == CW'(1)) begin
                r_state    <= RINGING;
                r_ring     <= 1'b1;
                r_snoozing <= 1'b0;
                r_ring_cnt <= CW'(RING_SECS);
              end
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_ring     <= 1'b0;
          r_snoozing <= 1'b0;
        end
      endcase
    end
  end

  assign ring         = r_ring;
  assign ring_id      = r_ring_id;
  assign snoozing     = r_snoozing;
  assign missed       = r_missed;
  assign bus.alarm_en = r_alarm_en;
  assign bus.wr_err   = r_wr_err;
endmodule

// File: tb/tb_alarm_bank.sv
module tb_alarm_bank;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] hh_mm_ss;
  logic        am_pm, mode12h, snooze_btn, stop_btn;
  logic        ring, snoozing, missed;
  logic [1:0]  ring_id;

  int n_cmp = 0;
  int n_bad = 0;
  int n_err_cyc = 0;
  int e0;

  alarm_bank_if bus ();

  alarm_bank #(.RING_SECS(3), .SNOOZE_SECS(5), .MAX_SNOOZE(1)) dut (
    .clk(clk), .rst(rst), .hh_mm_ss(hh_mm_ss), .am_pm(am_pm), .mode12h(mode12h),
    .bus(bus), .snooze_btn(snooze_btn), .stop_btn(stop_btn),
    .ring(ring), .ring_id(ring_id), .snoozing(snoozing), .missed(missed)
  );

  always #5 clk = ~clk;

  // wr_err high-cycle count; a single rejected write adds exactly one.
  always @(negedge clk) if (bus.wr_err === 1'b1) n_err_cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pk(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    return {h[5:0], m[6:0], s[6:0]};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a new live time and let the match/tick edge pass.
  task automatic set_t(input logic [19:0] t, input logic pm);
    @(posedge clk); #1;
    hh_mm_ss = t;
    am_pm    = pm;
    cyc(2);
  endtask

  task automatic wr(input logic [1:0] id, input logic [19:0] t, input logic pm);
    bus.alarm_id    = id;
    bus.stime_alarm = t;
    bus.sam_pm      = pm;
    bus.set_alarm   = 1'b1;
    cyc(3);
    bus.set_alarm   = 1'b0;
    cyc(3);
  endtask

  task automatic clr(input logic [1:0] id);
    bus.alarm_id  = id;
    bus.clr_alarm = 1'b1;
    cyc(3);
    bus.clr_alarm = 1'b0;
    cyc(3);
  endtask

  task automatic press_stop();
    stop_btn = 1'b1; cyc(3); stop_btn = 1'b0; cyc(3);
  endtask

  task automatic press_snooze();
    snooze_btn = 1'b1; cyc(3); snooze_btn = 1'b0; cyc(3);
  endtask

  initial begin
    hh_mm_ss = '0; am_pm = 0; mode12h = 0; snooze_btn = 0; stop_btn = 0;
    bus.set_alarm = 0; bus.clr_alarm = 0; bus.alarm_id = 0; bus.stime_alarm = '0; bus.sam_pm = 0;
    cyc(3);
    chk("rst_outs", {28'd0, ring, snoozing, missed, bus.wr_err}, 32'd0);
    chk("rst_en", {28'd0, bus.alarm_en}, 32'd0);
    chk("rst_id", {30'd0, ring_id}, 32'd0);
    rst = 1'b1;
    cyc(2);

    // 24h write and exact trigger latency
    wr(2'd2, pk(8'h07, 8'h30, 8'h00), 0);
    chk("t1_en", {28'd0, bus.alarm_en}, 32'h4);
    set_t(pk(8'h07, 8'h29, 8'h59), 0);
    @(posedge clk); #1;
    hh_mm_ss = pk(8'h07, 8'h30, 8'h00);
    @(negedge clk);
    chk("t1_ring_before", {31'd0, ring}, 32'd0);
    @(posedge clk); #1;
    chk("t1_ring", {31'd0, ring}, 32'd1);
    chk("t1_id", {30'd0, ring_id}, 32'd2);
    press_stop();
    chk("t1_stop", {31'd0, ring}, 32'd0);

    // 12h conversion: 12:05 AM -> 00:05
    mode12h = 1'b1;
    wr(2'd0, pk(8'h12, 8'h05, 8'h00), 0);
    chk("t2_en", {28'd0, bus.alarm_en}, 32'h5);
    set_t(pk(8'h12, 8'h04, 8'h59), 0);
    set_t(pk(8'h12, 8'h05, 8'h00), 0);
    chk("t2_am_ring", {29'd0, ring, ring_id}, 32'h4);
    press_stop();
    set_t(pk(8'h12, 8'h04, 8'h59), 1);
    set_t(pk(8'h12, 8'h05, 8'h00), 1);
    chk("t2_pm_noring", {31'd0, ring}, 32'd0);
    e0 = n_err_cyc;
    wr(2'd0, pk(8'h13, 8'h00, 8'h00), 0);
    chk("t2_wr_err", n_err_cyc - e0, 32'd1);
    chk("t2_en_keep", {28'd0, bus.alarm_en}, 32'h5);
    set_t(pk(8'h12, 8'h04, 8'h59), 0);
    set_t(pk(8'h12, 8'h05, 8'h00), 0);
    chk("t2_slot_keep", {29'd0, ring, ring_id}, 32'h4);
    press_stop();
    // 01:15 PM stored as 13:15, still matches after switching to 24h
    wr(2'd1, pk(8'h01, 8'h15, 8'h00), 1);
    mode12h = 1'b0;
    set_t(pk(8'h13, 8'h14, 8'h59), 0);
    set_t(pk(8'h13, 8'h15, 8'h00), 0);
    chk("t2_pm_conv", {29'd0, ring, ring_id}, 32'h5);
    press_stop();
    e0 = n_err_cyc;
    wr(2'd3, pk(8'h24, 8'h00, 8'h00), 0);
    wr(2'd3, pk(8'h10, 8'h60, 8'h00), 0);
    chk("t2_24h_errs", n_err_cyc - e0, 32'd2);
    chk("t2_en_7", {28'd0, bus.alarm_en}, 32'h7);
    clr(2'd0); clr(2'd1); clr(2'd2);
    chk("t2_clr_all", {28'd0, bus.alarm_en}, 32'h0);

    // Snooze cycle
    wr(2'd2, pk(8'h06, 8'h00, 8'h00), 0);
    set_t(pk(8'h05, 8'h59, 8'h59), 0);
    set_t(pk(8'h06, 8'h00, 8'h00), 0);
    chk("t3_ring", {29'd0, ring, ring_id}, 32'h6);
    press_snooze();
    chk("t3_snz", {30'd0, ring, snoozing}, 32'h1);
    for (int s = 1; s <= 4; s++) set_t(pk(8'h06, 8'h00, 8'(s)), 0);
    chk("t3_snz_4", {30'd0, ring, snoozing}, 32'h1);
    set_t(pk(8'h06, 8'h00, 8'h05), 0);
    chk("t3_rering", {30'd0, ring, snoozing}, 32'h2);
    press_snooze();
    chk("t3_snz_stop", {30'd0, ring, snoozing}, 32'h0);
    set_t(pk(8'h05, 8'h59, 8'h59), 0);
    set_t(pk(8'h06, 8'h00, 8'h00), 0);
    set_t(pk(8'h06, 8'h00, 8'h01), 0);
    set_t(pk(8'h06, 8'h00, 8'h02), 0);
    chk("t3_ring_2t", {31'd0, ring}, 32'd1);
    set_t(pk(8'h06, 8'h00, 8'h03), 0);
    chk("t3_timeout", {31'd0, ring}, 32'd0);

    // Collision
    wr(2'd1, pk(8'h09, 8'h00, 8'h00), 0);
    wr(2'd3, pk(8'h09, 8'h00, 8'h00), 0);
    set_t(pk(8'h08, 8'h59, 8'h59), 0);
    set_t(pk(8'h09, 8'h00, 8'h00), 0);
    chk("t4_coll", {29'd0, ring, ring_id}, 32'h5);
    chk("t4_missed", {31'd0, missed}, 32'd1);
    press_stop();
    chk("t4_stop", {30'd0, ring, missed}, 32'h0);

    // Clear mid-ring, then stop and snooze together
    set_t(pk(8'h08, 8'h59, 8'h59), 0);
    set_t(pk(8'h09, 8'h00, 8'h00), 0);
    chk("t5_ring", {29'd0, ring, ring_id}, 32'h5);
    clr(2'd1);
    chk("t5_clr_ring", {31'd0, ring}, 32'd0);
    chk("t5_clr_en", {28'd0, bus.alarm_en}, 32'hC);
    set_t(pk(8'h08, 8'h59, 8'h59), 0);
    set_t(pk(8'h09, 8'h00, 8'h00), 0);
    chk("t5_ring3", {29'd0, ring, ring_id}, 32'h7);
    chk("t5_sticky", {31'd0, missed}, 32'd1);
    stop_btn = 1'b1; snooze_btn = 1'b1;
    cyc(3);
    stop_btn = 1'b0; snooze_btn = 1'b0;
    cyc(3);
    chk("t5_stop_wins", {29'd0, ring, snoozing, missed}, 32'h0);

    // Async reset while ringing
    set_t(pk(8'h08, 8'h59, 8'h59), 0);
    set_t(pk(8'h09, 8'h00, 8'h00), 0);
    chk("t6_ring", {29'd0, ring, ring_id}, 32'h7);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("t6_async", {26'd0, ring, ring_id, snoozing, missed, bus.wr_err}, 32'h0);
    chk("t6_async_en", {28'd0, bus.alarm_en}, 32'h0);
    cyc(2);
    rst = 1'b1;
    cyc(2);
    set_t(pk(8'h08, 8'h59, 8'h59), 0);
    set_t(pk(8'h09, 8'h00, 8'h00), 0);
    chk("t6_no_retrig", {31'd0, ring}, 32'd0);
    wr(2'd3, pk(8'h09, 8'h00, 8'h00), 0);
    set_t(pk(8'h08, 8'h59, 8'h59), 0);
    set_t(pk(8'h09, 8'h00, 8'h00), 0);
    chk("t6_rewrite", {29'd0, ring, ring_id}, 32'h7);
    press_stop();
    chk("t6_stop", {31'd0, ring}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alarm_bank.md
Name: alarm_bank

Overview:
- Downstream consumer of the time_view clock output and owner of the alarm store.
- Holds 4 alarm slots written through the same stime_alarm/alarm_id/set_alarm interface.
- Watches the live hh_mm_ss/am_pm stream and raises a ring request when a slot matches.
- Manages ring timeout, snooze and stop for the buzzer/LED driver stage.

Parameters:
- RING_SECS, 60: seconds a ring lasts before it auto-stops.
- SNOOZE_SECS, 300: seconds between a snooze press and the re-ring.
- MAX_SNOOZE, 3: snoozes allowed per trigger; the next snooze acts as stop.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- hh_mm_ss  in  20  live time, packed BCD {h10[19:18], h1[17:14], m10[13:11], m1[10:7], s10[6:4], s1[3:0]}.
- am_pm  in  1  live time PM flag; valid only when mode12h=1.
- mode12h  in  1  1 means hh_mm_ss and stime_alarm use 12h format (01-12).
- set_alarm  in  1  write-slot strobe; rising edge acts.
- clr_alarm  in  1  disable-slot strobe; rising edge acts.
- alarm_id  in  2  target slot for set_alarm/clr_alarm.
- stime_alarm  in  20  alarm time, same packing as hh_mm_ss; seconds field ignored.
- sam_pm  in  1  PM flag for stime_alarm in 12h mode.
- snooze_btn  in  1  snooze button level; rising edge acts.
- stop_btn  in  1  stop button level; rising edge acts.
- ring  out  1  ring request.
- ring_id  out  2  slot that is ringing or snoozing.
- snoozing  out  1  high in SNOOZE.
- alarm_en  out  4  per-slot enable.
- wr_err  out  1  one-cycle pulse on a rejected write.
- missed  out  1  sticky; set when a match is dropped.

Behaviour:
- Reset (async): all outputs 0, slots 00:00 disabled, FSM in IDLE, all counters 0, edge-detect history 0.
- Edge detect: every strobe and button input is registered; it acts on the 0->1 transition, one cycle after the input rises.
- Write path:
  - Convert stime_alarm to 24h through to_24h: 12AM->00, 12PM->12, 1-11PM -> +12 in BCD.
  - Validate: hour digits <=23, BCD digits <=9, m10 <=5; in 12h mode the hour must be 01-12.
  - Valid write: slot[alarm_id] <= {HH24, MM}, alarm_en[alarm_id] <= 1.
  - Invalid write: no state change, wr_err pulses.
- Clear path: alarm_en[alarm_id] <= 0. If that slot is ringing or snoozing, go to IDLE next cycle and reset the snooze count.
- Second tick: sec_tick = (hh_mm_ss[3:0] != previous registered s1).
- Time compare: live time is converted to 24h through a second to_24h instance.
- Match: on a sec_tick cycle, an enabled slot matches when HH:MM equals the live time and the live seconds are 00. Lowest slot id wins; other matches in the same cycle set missed.
- FSM states:
  - IDLE: on a match, load ring_id, ring_cnt <= RING_SECS, snz_cnt <= 0, go to RINGING. ring=1 the cycle after the match cycle.
  - RINGING (ring=1): stop edge -> IDLE. Snooze edge with snz_cnt < MAX_SNOOZE -> SNOOZE, wait_cnt <= SNOOZE_SECS, snz_cnt += 1. Snooze edge with snz_cnt == MAX_SNOOZE -> acts as stop. Each sec_tick decrements ring_cnt; the decrement 1->0 goes to IDLE.
  - SNOOZE (snoozing=1, ring=0): stop edge -> IDLE. Each sec_tick decrements wait_cnt; 1->0 goes to RINGING with ring_cnt <= RING_SECS.
  - In RINGING and SNOOZE, any new match sets missed.
- Priority on the same cycle: clr of the active slot > stop > snooze > tick.
- missed clears on a stop edge or reset.
- Writing the active slot while RINGING/SNOOZE updates the stored time only; the FSM is unaffected.
- Toggling mode12h has no effect on stored slots, which are always 24h internally.
- Counter widths: $clog2(max(RING_SECS, SNOOZE_SECS)+1).

Decomposition:
- Shared package clock_pkg:
  - Packed-time field offsets and widths.
  - 24h time typedef {hh[5:0], mm[6:0]}.
  - FSM state enum {IDLE, RINGING, SNOOZE}.
  - BCD validity function.
- Sub-module to_24h: combinational 12h->24h BCD converter. Inputs: hour[5:0], pm, mode12h. Outputs: hour24[5:0], valid. Instantiated twice (write path and compare path).

Test Plan:
- Write and trigger (24h): write slot 2 = 07:30, then drive time 07:29:59 -> 07:30:00. Expect ring=1, ring_id=2 one cycle after the 07:30:00 cycle. Expect alarm_en=4'b0100.
- 12h conversion: mode12h=1, set slot 0 = 12:05 with sam_pm=0; drive 12:05:00 with am_pm=0 -> ring. Repeat with am_pm=1 -> no ring. Write 13:00 in 12h mode -> wr_err pulses, slot unchanged.
- Snooze cycle (RING_SECS=3, SNOOZE_SECS=5, MAX_SNOOZE=1):
  - Snooze while ringing -> snoozing=1, ring=0; after 5 ticks ring=1.
  - Second snooze -> IDLE.
  - With no press, ring drops after 3 ticks.
- Collision: slots 1 and 3 both = 09:00 -> ring_id=1, missed=1; stop edge -> ring=0, missed=0.
- Clear mid-ring: clr_alarm on the ringing slot -> ring=0 next cycle. Same cycle stop+snooze -> stop wins.
- Async reset: assert rst=0 while RINGING -> all outputs 0 immediately; after release, the old time does not re-trigger until a slot is rewritten.
